// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and constants for the LFSR word arbiter.
// Optional feature macro: LFSR_PERIOD_CHECK_EN (period_wrap output).
package lfsr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DEF_TAPS = 8'h2D;

    // Bits needed to count 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lfsr_gal_core.sv
// Galois LFSR state register with step and seed-load datapath.
// Macro LFSR_PERIOD_CHECK_EN adds the period_wrap pulse output.
module lfsr_gal_core
    import lfsr_ctrl_pkg::*;
#(
    parameter int              LN   = 8,
    parameter logic [LN-1:0]   TAPS = LN'(DEF_TAPS)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          step,
    input  logic          load,
    input  logic [LN-1:0] load_val,
`ifdef LFSR_PERIOD_CHECK_EN
    output logic          period_wrap,
`endif
    output logic [LN-1:0] sreg
);

    logic [LN-1:0] r_sreg;
    logic [LN-1:0] w_next;
    logic [LN-1:0] w_load;
    logic          w_v;

    // Next state for one step, and the zero-safe load value.
    always_comb begin
        w_v    = r_sreg[0];
        w_next = {w_v, r_sreg[LN-1:1]} ^ (w_v ? TAPS : '0);
        w_load = (load_val == '0) ? LN'(1) : load_val;
    end

    // State register: load wins over step; the all-zero state is unreachable.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_sreg <= LN'(1);
        end else if (load) begin
            r_sreg <= w_load;
        end else if (step) begin
            r_sreg <= w_next;
        end
    end

    assign sreg = r_sreg;

`ifdef LFSR_PERIOD_CHECK_EN
    logic [LN-1:0] r_saved;
    logic          r_wrap;

    // Remember the last loaded seed and flag a step that returns to it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_saved <= LN'(1);
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= step && !load && (w_next == r_saved);
            if (load) begin
                r_saved <= w_load;
            end
        end
    end

    assign period_wrap = r_wrap;
`endif

endmodule

// File: rtl/lfsr_word_arbiter.sv
// Two-requester round-robin arbiter over one Galois LFSR word generator.
// Macro LFSR_PERIOD_CHECK_EN adds the period_wrap output.
module lfsr_word_arbiter
    import lfsr_ctrl_pkg::*;
#(
    parameter int            LN   = 8,
    parameter logic [LN-1:0] TAPS = LN'(DEF_TAPS),
    parameter int            WW   = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          seed_valid,
    input  logic [LN-1:0] seed_data,
    output logic          seed_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [WW-1:0] rsp_data,
    input  logic          rsp_ready,
`ifdef LFSR_PERIOD_CHECK_EN
    output logic          period_wrap,
`endif
    output logic          busy
);

    localparam int            CW       = clog2(WW);
    localparam logic [CW-1:0] CNT_LAST = CW'(WW - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_rr_last;
    logic          r_id;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_word;
    logic [WW-1:0] w_word_nx;
    logic [LN-1:0] w_sreg;
    logic          w_step;
    logic          w_load;
    logic          w_grant;
    logic          w_gid;

    lfsr_gal_core #(
        .LN   (LN),
        .TAPS (TAPS)
    ) u_core (
        .CLK         (CLK),
        .nRST        (nRST),
        .step        (w_step),
        .load        (w_load),
        .load_val    (seed_data),
`ifdef LFSR_PERIOD_CHECK_EN
        .period_wrap (period_wrap),
`endif
        .sreg        (w_sreg)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, seed/grant handshakes and LFSR control.
    always_comb begin
        w_state_nx = r_state;
        seed_ready = 1'b0;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_grant    = 1'b0;
        w_gid      = 1'b0;
        unique case (r_state)
            IDLE: begin
                seed_ready = seed_valid;
                if (seed_valid) begin
                    w_load = 1'b1;
                end else if (req0_valid || req1_valid) begin
                    w_grant    = 1'b1;
                    w_gid      = (req0_valid && req1_valid) ?
                                 ~r_rr_last : req1_valid;
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        req0_ready = w_grant && !w_gid;
        req1_ready = w_grant && w_gid;
    end

    // Shift the pre-step LFSR bit in at the top; first bit ends at LSB.
    always_comb begin
        w_word_nx         = r_word >> 1;
        w_word_nx[WW-1]   = w_sreg[0];
    end

    // Round-robin pointer, owner id, step counter and word assembly.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_rr_last <= 1'b1;
            r_id      <= 1'b0;
            r_cnt     <= '0;
            r_word    <= '0;
        end else begin
            if (w_grant) begin
                r_rr_last <= w_gid;
                r_id      <= w_gid;
                r_cnt     <= '0;
            end
            if (w_step) begin
                r_word <= w_word_nx;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = r_id;
    assign rsp_data  = r_word;
    assign busy      = (r_state != IDLE);

endmodule
